// File: rtl/riscv_alu_seq.sv
// riscv_alu_seq: handshaked RISC-V integer ALU with an iterative shifter.
// Moves at most SHIFT_STEP bits per cycle; one op in flight.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i                  drop the op in flight (sync)
//   req_valid_i/req_ready_o  request handshake
//   req_op_i, req_a_i,
//   req_b_i, req_tag_i       request payload
//   resp_valid_o/resp_ready_i response handshake
//   resp_result_o, resp_tag_o response payload
//   busy_o                   state is not IDLE
module riscv_alu_seq #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4,
    parameter int TAG_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_result_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             busy_o
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] STEP_W = (SW+1)'(SHIFT_STEP);

    localparam logic [3:0] ALU_NONE             = 4'd0;
    localparam logic [3:0] ALU_SHIFTL           = 4'd1;
    localparam logic [3:0] ALU_SHIFTR           = 4'd2;
    localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd3;
    localparam logic [3:0] ALU_ADD              = 4'd4;
    localparam logic [3:0] ALU_SUB              = 4'd6;
    localparam logic [3:0] ALU_AND              = 4'd7;
    localparam logic [3:0] ALU_OR               = 4'd8;
    localparam logic [3:0] ALU_XOR              = 4'd9;
    localparam logic [3:0] ALU_LESS_THAN        = 4'd10;
    localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic [3:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] tagp_q, tagp_d;

    // Clamp a shift amount to the per-cycle step.
    function automatic logic [SW-1:0] clamp_step(input logic [SW-1:0] v);
        if ({1'b0, v} > STEP_W) begin
            return STEP_W[SW-1:0];
        end
        return v;
    endfunction

    // Arithmetic right shift of the accumulator keeps replicating
    // the operand-A sign bit captured at accept.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] v,
        input logic [SW-1:0]    amt,
        input logic [3:0]       op
    );
        case (op)
            ALU_SHIFTL:       return v << amt;
            ALU_SHIFTR:       return v >> amt;
            ALU_SHIFTR_ARITH: return $unsigned($signed(v) >>> amt);
            default:          return v;
        endcase
    endfunction

    logic             accept;
    logic             is_shift;
    logic [SW-1:0]    n;
    logic [SW-1:0]    first_amt;
    logic [SW-1:0]    step_amt;
    logic [WIDTH-1:0] first_sh;
    logic [WIDTH-1:0] step_sh;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_u;
    logic             lt_s;
    logic [WIDTH-1:0] alu_res;

    assign req_ready_o = !flush_i &&
                         (state_q == S_IDLE ||
                          (state_q == S_DONE && resp_ready_i));
    assign accept    = req_valid_i && req_ready_o;
    assign is_shift  = req_op_i == ALU_SHIFTL ||
                       req_op_i == ALU_SHIFTR ||
                       req_op_i == ALU_SHIFTR_ARITH;
    assign n         = req_b_i[SW-1:0];
    assign first_amt = clamp_step(n);
    assign step_amt  = clamp_step(rem_q);
    assign first_sh  = shift_by(req_a_i, first_amt, req_op_i);
    assign step_sh   = shift_by(acc_q, step_amt, op_q);

    assign sum  = req_a_i + req_b_i;
    assign diff = req_a_i - req_b_i;
    assign lt_u = req_a_i < req_b_i;
    // Differing signs: A is less iff A is negative.
    assign lt_s = (req_a_i[WIDTH-1] ^ req_b_i[WIDTH-1]) ?
                  req_a_i[WIDTH-1] : diff[WIDTH-1];

    always_comb begin
        alu_res = req_a_i;
        case (req_op_i)
            ALU_ADD:              alu_res = sum;
            ALU_SUB:              alu_res = diff;
            ALU_AND:              alu_res = req_a_i & req_b_i;
            ALU_OR:               alu_res = req_a_i | req_b_i;
            ALU_XOR:              alu_res = req_a_i ^ req_b_i;
            ALU_LESS_THAN:        alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_LESS_THAN_SIGNED: alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_NONE:             alu_res = req_a_i;
            default:              alu_res = req_a_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        res_d   = res_q;
        tag_d   = tag_q;
        tagp_d  = tagp_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    acc_d = step_sh;
                    rem_d = rem_q - step_amt;
                    if (rem_q == step_amt) begin
                        state_d = S_DONE;
                        res_d   = step_sh;
                        tag_d   = tagp_q;
                    end
                end
                S_DONE: begin
                    if (resp_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
            // Accept only happens in IDLE or DONE, never in SHIFT.
            if (accept) begin
                op_d   = req_op_i;
                tagp_d = req_tag_i;
                if (is_shift && n != '0) begin
                    acc_d = first_sh;
                    rem_d = n - first_amt;
                    if (n == first_amt) begin
                        state_d = S_DONE;
                        res_d   = first_sh;
                        tag_d   = req_tag_i;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_DONE;
                    res_d   = alu_res;
                    tag_d   = req_tag_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            tagp_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            tagp_q  <= tagp_d;
        end
    end

    assign resp_valid_o  = state_q == S_DONE;
    assign resp_result_o = res_q;
    assign resp_tag_o    = tag_q;
    assign busy_o        = state_q != S_IDLE;

endmodule

// File: tb/tb_riscv_alu_seq.sv
// tb_riscv_alu_seq: scoreboard bench for riscv_alu_seq.
// Drives an RV32 and an RV64 instance through a shared request path.
module tb_riscv_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b1;
    logic        sel64 = 1'b0;
    logic [3:0]  req_op = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [4:0]  req_tag = '0;

    logic        rdy32, vld32, busy32;
    logic        rdy64, vld64, busy64;
    logic [31:0] res32;
    logic [63:0] res64;
    logic [4:0]  tag32, tag64;

    logic        rdy, vld, busy;
    logic [63:0] res;
    logic [4:0]  tago;

    assign rdy  = sel64 ? rdy64 : rdy32;
    assign vld  = sel64 ? vld64 : vld32;
    assign busy = sel64 ? busy64 : busy32;
    assign res  = sel64 ? res64 : {32'b0, res32};
    assign tago = sel64 ? tag64 : tag32;

    always #5 clk = ~clk;

    riscv_alu_seq #(.WIDTH(32), .SHIFT_STEP(4), .TAG_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid & ~sel64), .req_ready_o(rdy32),
        .req_op_i(req_op), .req_a_i(req_a[31:0]),
        .req_b_i(req_b[31:0]), .req_tag_i(req_tag),
        .resp_valid_o(vld32), .resp_ready_i(resp_ready),
        .resp_result_o(res32), .resp_tag_o(tag32), .busy_o(busy32)
    );

    riscv_alu_seq #(.WIDTH(64), .SHIFT_STEP(4), .TAG_W(5)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid & sel64), .req_ready_o(rdy64),
        .req_op_i(req_op), .req_a_i(req_a),
        .req_b_i(req_b), .req_tag_i(req_tag),
        .resp_valid_o(vld64), .resp_ready_i(resp_ready),
        .resp_result_o(res64), .resp_tag_o(tag64), .busy_o(busy64)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] model(
        input logic [3:0] op, input logic [63:0] a,
        input logic [63:0] b, input bit w64
    );
        logic [31:0] a32, b32, r32;
        logic [63:0] r;
        int n;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w64) begin
            n = int'(b[5:0]);
            case (op)
                4'd1:    r = a << n;
                4'd2:    r = a >> n;
                4'd3:    r = $signed(a) >>> n;
                4'd4:    r = a + b;
                4'd6:    r = a - b;
                4'd7:    r = a & b;
                4'd8:    r = a | b;
                4'd9:    r = a ^ b;
                4'd10:   r = (a < b) ? 64'd1 : 64'd0;
                4'd11:   r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                default: r = a;
            endcase
            return r;
        end
        n = int'(b[4:0]);
        case (op)
            4'd1:    r32 = a32 << n;
            4'd2:    r32 = a32 >> n;
            4'd3:    r32 = $signed(a32) >>> n;
            4'd4:    r32 = a32 + b32;
            4'd6:    r32 = a32 - b32;
            4'd7:    r32 = a32 & b32;
            4'd8:    r32 = a32 | b32;
            4'd9:    r32 = a32 ^ b32;
            4'd10:   r32 = (a32 < b32) ? 32'd1 : 32'd0;
            4'd11:   r32 = ($signed(a32) < $signed(b32)) ? 32'd1 : 32'd0;
            default: r32 = a32;
        endcase
        return {32'b0, r32};
    endfunction

    // Present a request, wait for accept, push its expectation.
    task automatic send(
        input logic [3:0] op, input logic [63:0] a,
        input logic [63:0] b, input logic [4:0] tag
    );
        int k;
        exp_t e;
        req_op = op;
        req_a = a;
        req_b = b;
        req_tag = tag;
        req_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL accept_timeout op=%0d ready=%b required 1",
                     op, rdy);
        end
        @(posedge clk);
        e.res = model(op, a, b, sel64);
        e.tag = tag;
        sb.push_back(e);
        #1 req_valid = 1'b0;
    endtask

    // Wait (bounded) for resp_valid; returns latency in edges.
    task automatic get_resp(
        output logic [63:0] r, output logic [4:0] t,
        output int lat, output bit busy_ok
    );
        busy_ok = 1'b1;
        lat = 1;
        @(negedge clk);
        if (!busy) busy_ok = 1'b0;
        while (!vld && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!busy) busy_ok = 1'b0;
        end
        r = res;
        t = tago;
    endtask

    task automatic test_reset;
        checks++;
        if (vld32 !== 1'b0 || busy32 !== 1'b0 || rdy32 !== 1'b1 ||
            res32 !== '0 || tag32 !== '0) begin
            errors++;
            $display("FAIL reset32 v=%b b=%b r=%b res=%h tag=%0d required 0 0 1 0 0",
                     vld32, busy32, rdy32, res32, tag32);
        end
        checks++;
        if (vld64 !== 1'b0 || busy64 !== 1'b0 || rdy64 !== 1'b1 ||
            res64 !== '0 || tag64 !== '0) begin
            errors++;
            $display("FAIL reset64 v=%b b=%b r=%b res=%h tag=%0d required 0 0 1 0 0",
                     vld64, busy64, rdy64, res64, tag64);
        end
    endtask

    task automatic test_arith;
        logic [3:0]  ops[9] = '{4'd4, 4'd6, 4'd11, 4'd10, 4'd5,
                                4'd7, 4'd8, 4'd9, 4'd0};
        logic [31:0] as[9]  = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
                                32'h8000_0000, 32'h1234_5678,
                                32'hF0F0_1234, 32'h0F00_00A0,
                                32'hAAAA_5555, 32'hCAFE_F00D};
        logic [31:0] bs[9]  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h9,
                                32'hFF00_FF00, 32'h00F0_0005,
                                32'hFFFF_0000, 32'h3};
        logic [63:0] r;
        logic [4:0]  t;
        int lat;
        bit bo;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            send(ops[i], {32'b0, as[i]}, {32'b0, bs[i]}, 5'(i + 3));
            get_resp(r, t, lat, bo);
            e = sb.pop_front();
            checks++;
            if (r !== e.res || t !== e.tag) begin
                errors++;
                $display("FAIL arith_op%0d got %h/%0d required %h/%0d",
                         ops[i], r, t, e.res, e.tag);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL arith_lat_op%0d got %0d required 1",
                         ops[i], lat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_shift;
        logic [3:0]  ops[5]  = '{4'd3, 4'd1, 4'd2, 4'd2, 4'd1};
        logic [31:0] as[5]   = '{32'h8000_0000, 32'h1, 32'hDEAD_BEEF,
                                 32'hF000_0000, 32'h0000_0F0F};
        logic [31:0] bs[5]   = '{32'd31, 32'h25, 32'h0,
                                 32'h24, 32'd12};
        int          lats[5] = '{8, 2, 1, 1, 3};
        logic [63:0] r;
        logic [4:0]  t;
        int lat;
        bit bo;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            send(ops[i], {32'b0, as[i]}, {32'b0, bs[i]}, 5'(20 + i));
            get_resp(r, t, lat, bo);
            e = sb.pop_front();
            checks++;
            if (r !== e.res || t !== e.tag) begin
                errors++;
                $display("FAIL shift_%0d got %h/%0d required %h/%0d",
                         i, r, t, e.res, e.tag);
            end
            checks++;
            if (lat !== lats[i] || !bo) begin
                errors++;
                $display("FAIL shift_lat_%0d got %0d busy_ok=%b required %0d 1",
                         i, lat, bo, lats[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_pressure;
        logic [63:0] r;
        logic [4:0]  t;
        int lat;
        bit bo;
        bit ok;
        exp_t e;
        resp_ready = 1'b0;
        send(4'd4, 64'd5, 64'd7, 5'd9);
        get_resp(r, t, lat, bo);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res !== r || tago !== t || !vld || rdy) ok = 1'b0;
        end
        checks++;
        if (!ok || !vld) begin
            errors++;
            $display("FAIL bp_hold res=%h tag=%0d v=%b rdy=%b required %h %0d 1 0",
                     res, tago, vld, rdy, r, t);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        req_op = 4'd4;
        req_a = 64'd100;
        req_b = 64'd23;
        req_tag = 5'd12;
        req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb got %b required 1", rdy);
        end
        @(posedge clk);
        e = sb.pop_front();
        checks++;
        if (r !== e.res || t !== e.tag) begin
            errors++;
            $display("FAIL bp_first got %h/%0d required %h/%0d",
                     r, t, e.res, e.tag);
        end
        e.res = model(4'd4, 64'd100, 64'd23, 1'b0);
        e.tag = 5'd12;
        sb.push_back(e);
        #1 req_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (vld !== 1'b1 || res !== e.res || tago !== e.tag) begin
            errors++;
            $display("FAIL bp_second v=%b got %h/%0d required 1 %h/%0d",
                     vld, res, tago, e.res, e.tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush;
        logic [63:0] r;
        logic [4:0]  t;
        int lat;
        bit bo;
        bit seen;
        send(4'd3, 64'h8000_0000, 64'd31, 5'd4);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || vld !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush_shift busy=%b v=%b rdy=%b required 0 0 1",
                     busy, vld, rdy);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (vld) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_resp got valid required none");
        end
        // Flush while DONE is being handshaken, with a request waiting.
        send(4'd8, 64'h0000_1100, 64'h0000_0022, 5'd6);
        get_resp(r, t, lat, bo);
        sb.delete();
        flush = 1'b1;
        req_op = 4'd4;
        req_a = 64'd1;
        req_b = 64'd1;
        req_tag = 5'd1;
        req_valid = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b required 0", rdy);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (vld || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_done valid_or_busy seen required idle");
        end
    endtask

    task automatic test_reset_mid;
        send(4'd3, 64'h8000_0000, 64'd31, 5'd7);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (vld !== 1'b0 || busy !== 1'b0 || res !== '0 || tago !== '0) begin
            errors++;
            $display("FAIL reset_mid v=%b busy=%b res=%h tag=%0d required 0 0 0 0",
                     vld, busy, res, tago);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after rdy=%b busy=%b required 1 0",
                     rdy, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_w64;
        logic [3:0]  ops[4]  = '{4'd2, 4'd2, 4'd4, 4'd3};
        logic [63:0] as[4]   = '{64'h8000_0000_0000_0000,
                                 64'h8000_0000_0000_0000,
                                 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'h8000_0000_0000_0000};
        logic [63:0] bs[4]   = '{64'd63, 64'h43, 64'd2, 64'd40};
        int          lats[4] = '{16, 1, 1, 10};
        logic [63:0] r;
        logic [4:0]  t;
        int lat;
        bit bo;
        exp_t e;
        sel64 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], as[i], bs[i], 5'(i + 1));
            get_resp(r, t, lat, bo);
            e = sb.pop_front();
            checks++;
            if (r !== e.res || t !== e.tag) begin
                errors++;
                $display("FAIL w64_%0d got %h/%0d required %h/%0d",
                         i, r, t, e.res, e.tag);
            end
            checks++;
            if (lat !== lats[i] || !bo) begin
                errors++;
                $display("FAIL w64_lat_%0d got %0d busy_ok=%b required %0d 1",
                         i, lat, bo, lats[i]);
            end
            @(posedge clk);
            #1;
        end
        sel64 = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        @(posedge clk);
        #1;
        test_arith();
        test_shift();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        test_w64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_alu_seq.md
# riscv_alu_seq

Parametrised, handshaked successor to the combinational RISC-V integer ALU. It executes the same `ALU_*` operation set at configurable datapath width (RV32/RV64) and returns each result through a registered valid/ready response port. Shifts run on an iterative shifter that moves `SHIFT_STEP` bits per cycle, trading latency for area. The block sits in the execute stage behind issue and supports back-pressure and pipeline flush.

## Interface
- `WIDTH`, 32: datapath width; legal values are 32 or 64.
- `SHIFT_STEP`, 4: maximum bits shifted per cycle; a power of 2 in the range 1..`WIDTH`.
- `TAG_W`, 5: width of the opaque tag carried from request to response.
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `flush_i`  in  1  synchronous abort of the operation in flight.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when both valid and ready are high.
- `req_op_i`  in  4  operation code, `ALU_*` encoding from `riscv_defs_pkg.sv`.
- `req_a_i`  in  `WIDTH`  operand A.
- `req_b_i`  in  `WIDTH`  operand B; for shifts, only the shift amount bits are used.
- `req_tag_i`  in  `TAG_W`  request tag.
- `resp_valid_o`  out  1  result valid.
- `resp_ready_i`  in  1  consumer ready.
- `resp_result_o`  out  `WIDTH`  result.
- `resp_tag_o`  out  `TAG_W`  tag captured at accept.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- **Operation codes:**
  - NONE=0: result = A.
  - SHIFTL=1, SHIFTR=2, SHIFTR_ARITH=3.
  - ADD=4, SUB=6, AND=7, OR=8, XOR=9.
  - LESS_THAN=10 (unsigned) and LESS_THAN_SIGNED=11; both return 1 or 0, zero-extended to `WIDTH`.
  - Any undefined code returns A.
- **Arithmetic:** all arithmetic wraps modulo 2^`WIDTH`; no flags are produced. The signed compare is derived from sign bits and the subtract MSB.
- **Shift amount:** n = B[log2(`WIDTH`)-1:0]. Higher bits of B are ignored.
- **Arithmetic right shift:** fills with A[`WIDTH`-1], captured at accept.
- **States:**
  - IDLE: waiting for a request.
  - SHIFT: iterating a shift.
  - DONE: result held on the response port.
- **Accept, non-shift op or n=0:** result is computed and registered; state goes to DONE.
- **Accept, shift with n>0:**
  - The accumulator loads A shifted by s = min(n, `SHIFT_STEP`), and remaining = n - s.
  - If remaining = 0, state goes to DONE; otherwise state goes to SHIFT.
- **SHIFT, each cycle:**
  - Shift the accumulator by min(remaining, `SHIFT_STEP`) and decrement remaining by that amount.
  - When remaining reaches 0, state goes to DONE and the accumulator is copied to `resp_result_o`.
- **DONE:**
  - `resp_valid_o` = 1. Result and tag stay stable until `resp_ready_i` is high.
  - On handshake, state goes to IDLE, or directly accepts a new request if one is presented.
- **Request ready:**
  - `req_ready_o` = !`flush_i` && (IDLE || (DONE && `resp_ready_i`)).
  - This is a combinational path from `resp_ready_i` by design; it gives throughput of 1 op/cycle for non-shift ops.
- **Flush (`flush_i` high):** highest priority; takes effect at the next edge.
  - Any state goes to IDLE.
  - `resp_valid_o` goes to 0.
  - Any pending result is discarded, including one being handshaken in the same cycle.
  - No request is accepted that cycle.
- **Reset (`rst_ni` low):** takes effect at any time, including mid-shift.
  - State goes to IDLE.
  - `resp_valid_o`, `resp_result_o`, `resp_tag_o`, `busy_o`, the accumulator and the remaining counter all go to 0.
  - `req_ready_o` is 1 once out of reset (subject to `flush_i`).

## Timing
- Latency counts rising edges from the accept edge to the edge after which `resp_valid_o` is first seen high.
  - Non-shift op, or shift with n=0: 1 cycle.
  - Shift: max(1, ceil(n/`SHIFT_STEP`)).
  - Worst case: `WIDTH`/`SHIFT_STEP` cycles, which is 8 for the defaults.
- `SHIFT_STEP`=`WIDTH` makes every op single-cycle; the SHIFT state is then never entered.
- `resp_valid_o` never drops without a handshake, flush, or reset.
- `resp_result_o` and `resp_tag_o` change only at the edge where DONE is entered.
- At most one op is in flight; there is no reordering.

## Test plan
- ADD with A=0xFFFFFFFF, B=1, tag 3 -> result 0x00000000, tag 3, `resp_valid_o` high 1 cycle after accept; SUB with A=0, B=1 -> 0xFFFFFFFF.
- A=0x80000000, B=1 -> LESS_THAN_SIGNED returns 1 and LESS_THAN returns 0; an undefined op code 5 returns A.
- Shifts with `SHIFT_STEP`=4:
  - SHIFTR_ARITH, A=0x80000000, B=31 -> 0xFFFFFFFF after 8 cycles, `busy_o` high throughout.
  - SHIFTL, A=1, B=0x25 (n=5) -> 0x00000020 after 2 cycles.
  - SHIFTR, B=0 -> result A after 1 cycle.
- Back-pressure: hold `resp_ready_i` low for 5 cycles in DONE -> result and tag stable, `req_ready_o` low. Then raise `resp_ready_i` with a new ADD request valid in the same cycle -> both handshakes occur, and the new result appears 1 cycle later.
- Flush and reset mid-shift:
  - Assert `flush_i` in cycle 3 of an 8-cycle shift -> no response is produced, state is IDLE next edge, and `req_ready_o` is high once flush drops.
  - Assert `rst_ni` low mid-shift asynchronously -> all outputs take their reset values immediately.
- `WIDTH`=64, `SHIFT_STEP`=4:
  - SHIFTR with A=0x8000000000000000, B=63 -> result 1 after 16 cycles.
  - B=0x43 shifts by 3, confirming bits above B[5] are ignored.
